// File: rtl/alu_seq_if.sv
// Request/response bundle between decode and alu_seq: valid/ready request in,
// registered result, accumulator and flags out.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] val;
  logic             acc_we;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] acc;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_illegal;

  modport master (
    output in_valid, op, val, acc_we,
    input  in_ready, out_valid, result, acc, flag_zero, flag_carry, flag_illegal
  );

  modport slave (
    input  in_valid, op, val, acc_we,
    output in_ready, out_valid, result, acc, flag_zero, flag_carry, flag_illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with accumulator, optional unsigned saturation and a
// one-bit-per-cycle shifter. The interface WIDTH must match this WIDTH.
//
// state | meaning
// IDLE  | ready; single-cycle ops complete on the accept edge
// SHIFT | shifting work register one bit per edge until count reaches 0
module alu_seq #(
  parameter int WIDTH     = 8,
  parameter bit SAT_ARITH = 1'b0,
  parameter int SHW       = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OP_PASS_VAL = 4'b0000;
  localparam logic [3:0] OP_PASS_ACC = 4'b0001;
  localparam logic [3:0] OP_ADD      = 4'b0010;
  localparam logic [3:0] OP_SUB      = 4'b0011;
  localparam logic [3:0] OP_AND      = 4'b0100;
  localparam logic [3:0] OP_LSHFT    = 4'b0101;
  localparam logic [3:0] OP_RSHFT    = 4'b0110;
  localparam logic [3:0] OP_DIST     = 4'b0111;
  localparam logic [3:0] OP_MIN      = 4'b1000;

  localparam logic [SHW-1:0] SH_LIMIT = SHW'(WIDTH);
  localparam logic [SHW-1:0] SH_ONE   = SHW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             we_q, we_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rdiff;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             start_shift;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic             op_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      result_q    <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      we_q        <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      we_q        <= we_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, bus.val};
    diff        = {1'b0, acc_q} - {1'b0, bus.val};
    rdiff       = bus.val - acc_q;
    shamt       = bus.val[SHW-1:0];
    is_shift    = (bus.op == OP_LSHFT) || (bus.op == OP_RSHFT);
    start_shift = is_shift && (shamt != '0) && (shamt < SH_LIMIT);
    shifted     = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};

    op_res     = acc_q;
    op_carry   = 1'b0;
    op_illegal = 1'b0;
    case (bus.op)
      OP_PASS_VAL: op_res = bus.val;
      OP_PASS_ACC: op_res = acc_q;
      OP_ADD: begin
        op_carry = sum[WIDTH];
        op_res   = (SAT_ARITH && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        op_carry = diff[WIDTH];
        op_res   = (SAT_ARITH && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      end
      OP_AND:   op_res = acc_q & bus.val;
      // Only the degenerate shift amounts reach here; real shifts go through SHIFT.
      OP_LSHFT,
      OP_RSHFT: op_res = (shamt == '0) ? acc_q : '0;
      OP_DIST:  op_res = diff[WIDTH] ? rdiff : diff[WIDTH-1:0];
      OP_MIN:   op_res = diff[WIDTH] ? acc_q : bus.val;
      default:  op_illegal = 1'b1;
    endcase

    state_d     = state_q;
    acc_d       = acc_q;
    result_d    = result_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    we_d        = we_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (start_shift) begin
            state_d = SHIFT;
            work_d  = acc_q;
            cnt_d   = shamt;
            left_d  = (bus.op == OP_LSHFT);
            we_d    = bus.acc_we;
          end else begin
            result_d    = op_res;
            zero_d      = (op_res == '0);
            carry_d     = op_carry;
            illegal_d   = op_illegal;
            out_valid_d = 1'b1;
            if (bus.acc_we && !op_illegal) acc_d = op_res;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - SH_ONE;
        if (cnt_q == SH_ONE) begin
          state_d     = IDLE;
          result_d    = shifted;
          zero_d      = (shifted == '0);
          carry_d     = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          if (we_q) acc_d = shifted;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.acc          = acc_q;
  assign bus.flag_zero    = zero_q;
  assign bus.flag_carry   = carry_q;
  assign bus.flag_illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a wrapping and a saturating instance share one request
// stream and are checked against an arithmetic model with a result queue.
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [3:0] OP_PASS_VAL = 4'b0000;
  localparam logic [3:0] OP_PASS_ACC = 4'b0001;
  localparam logic [3:0] OP_ADD      = 4'b0010;
  localparam logic [3:0] OP_SUB      = 4'b0011;
  localparam logic [3:0] OP_LSHFT    = 4'b0101;
  localparam logic [3:0] OP_RSHFT    = 4'b0110;
  localparam logic [3:0] OP_DIST     = 4'b0111;
  localparam logic [3:0] OP_MIN      = 4'b1000;
  localparam logic [3:0] OP_UNK      = 4'b1111;

  typedef struct {
    int unsigned r0, r1, a0, a1, c0, c1, il, done;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned cyc;
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned macc0, macc1;
  int unsigned ready_edge;
  int unsigned last_r0, last_r1, last_c0, last_c1, last_il, last_z0;
  exp_t q[$];

  alu_seq_if #(.WIDTH(W)) ifc0 ();
  alu_seq_if #(.WIDTH(W)) ifc1 ();

  assign ifc1.in_valid = ifc0.in_valid;
  assign ifc1.op       = ifc0.op;
  assign ifc1.val      = ifc0.val;
  assign ifc1.acc_we   = ifc0.acc_we;

  alu_seq #(.WIDTH(W), .SAT_ARITH(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  alu_seq #(.WIDTH(W), .SAT_ARITH(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference behaviour from the op definitions; lat = edges spent in SHIFT.
  function automatic void model(input int unsigned op, input int unsigned a, input int unsigned b,
                                input bit sat, output int unsigned r, output int unsigned c,
                                output int unsigned il, output int unsigned lat);
    int unsigned n;
    r = a; c = 0; il = 0; lat = 0;
    n = b % 16;
    case (op)
      0: r = b;
      1: r = a;
      2: begin
        r = a + b;
        if (r > 255) begin c = 1; r = sat ? 255 : r - 256; end
      end
      3: begin
        if (a < b) begin c = 1; r = sat ? 0 : a + 256 - b; end
        else r = a - b;
      end
      4: r = a & b;
      5: if (n < 8) begin r = (a << n) % 256; lat = n; end else r = 0;
      6: if (n < 8) begin r = a >> n; lat = n; end else r = 0;
      7: r = (a > b) ? a - b : b - a;
      8: r = (a < b) ? a : b;
      default: il = 1;
    endcase
  endfunction

  task automatic req(input logic [3:0] op, input logic [7:0] v, input bit we);
    int unsigned want_edge, r0, r1, c0, c1, il, lat;
    int w;
    exp_t e;
    @(negedge clk);
    want_edge = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
    ifc0.in_valid = 1'b1;
    ifc0.op       = op;
    ifc0.val      = v;
    ifc0.acc_we   = we;
    w = 0;
    while (ifc0.in_ready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (ifc0.in_ready !== 1'b1) begin
      check_val("accept_timeout", 32'(ifc0.in_ready), 32'd1);
      ifc0.in_valid = 1'b0;
      return;
    end
    check_val("accept_edge", cyc + 1, want_edge);
    model(32'(op), macc0, 32'(v), 1'b0, r0, c0, il, lat);
    model(32'(op), macc1, 32'(v), 1'b1, r1, c1, il, lat);
    if (we && il == 0) begin
      macc0 = r0;
      macc1 = r1;
    end
    e.r0 = r0; e.r1 = r1; e.a0 = macc0; e.a1 = macc1;
    e.c0 = c0; e.c1 = c1; e.il = il;
    e.done = cyc + 1 + lat;
    q.push_back(e);
    ready_edge = cyc + 2 + lat;
    @(posedge clk);
    #1;
    ifc0.in_valid = 1'b0;
  endtask

  task automatic expect_last(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    int w;
    w = 0;
    while (q.size() != 0 && w < 64) begin
      @(posedge clk);
      #2;
      w++;
    end
    check_val({tag, "_drain"}, 32'(q.size()), 32'd0);
    check_val({tag, "_r0"}, last_r0, 32'(e0));
    check_val({tag, "_r1"}, last_r1, 32'(e1));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifc0.out_valid === 1'b1 || ifc1.out_valid === 1'b1) begin
      check_val("ov_match", 32'(ifc1.out_valid), 32'(ifc0.out_valid));
      if (q.size() == 0) begin
        check_val("spurious_ov", 32'(ifc0.out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check_val("done_cyc", cyc, e.done);
        check_val("result0", 32'(ifc0.result), e.r0);
        check_val("result1", 32'(ifc1.result), e.r1);
        check_val("acc0", 32'(ifc0.acc), e.a0);
        check_val("acc1", 32'(ifc1.acc), e.a1);
        check_val("zero0", 32'(ifc0.flag_zero), (e.r0 == 0) ? 32'd1 : 32'd0);
        check_val("zero1", 32'(ifc1.flag_zero), (e.r1 == 0) ? 32'd1 : 32'd0);
        check_val("carry0", 32'(ifc0.flag_carry), e.c0);
        check_val("carry1", 32'(ifc1.flag_carry), e.c1);
        check_val("illegal0", 32'(ifc0.flag_illegal), e.il);
        check_val("illegal1", 32'(ifc1.flag_illegal), e.il);
        last_r0 = 32'(ifc0.result);
        last_r1 = 32'(ifc1.result);
        last_c0 = 32'(ifc0.flag_carry);
        last_c1 = 32'(ifc1.flag_carry);
        last_il = 32'(ifc0.flag_illegal);
        last_z0 = 32'(ifc0.flag_zero);
      end
    end
  end

  initial begin
    int unsigned r;
    logic [3:0] rop;
    cyc = 0; n_vec = 0; n_err = 0;
    macc0 = 0; macc1 = 0; ready_edge = 0;
    last_r0 = 0; last_r1 = 0; last_c0 = 0; last_c1 = 0; last_il = 0; last_z0 = 0;
    rst = 1'b1;
    ifc0.in_valid = 1'b0;
    ifc0.op       = 4'd0;
    ifc0.val      = 8'd0;
    ifc0.acc_we   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_val("rst_result", 32'(ifc0.result), 32'd0);
    check_val("rst_acc", 32'(ifc0.acc), 32'd0);
    check_val("rst_out_valid", 32'(ifc0.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(ifc0.in_ready), 32'd1);
    check_val("rst_flags", 32'({ifc0.flag_zero, ifc0.flag_carry, ifc0.flag_illegal}), 32'd0);
    check_val("rst_acc1", 32'(ifc1.acc), 32'd0);

    req(OP_PASS_VAL, 8'h5A, 1'b1);
    expect_last("pass_val", 8'h5A, 8'h5A);
    check_val("pass_val_acc", 32'(ifc0.acc), 32'h5A);

    req(OP_PASS_VAL, 8'hF0, 1'b1);
    req(OP_ADD, 8'h20, 1'b0);
    expect_last("add_ovf", 8'h10, 8'hFF);
    check_val("add_carry0", last_c0, 32'd1);
    check_val("add_carry1", last_c1, 32'd1);

    req(OP_PASS_VAL, 8'h10, 1'b1);
    req(OP_SUB, 8'h30, 1'b0);
    expect_last("sub_brw", 8'hE0, 8'h00);
    check_val("sub_carry0", last_c0, 32'd1);
    req(OP_DIST, 8'h30, 1'b0);
    expect_last("dist", 8'h20, 8'h20);
    req(OP_MIN, 8'h30, 1'b0);
    expect_last("min", 8'h10, 8'h10);
    check_val("min_carry0", last_c0, 32'd0);

    req(OP_PASS_VAL, 8'h81, 1'b1);
    req(OP_LSHFT, 8'h03, 1'b1);
    req(OP_PASS_ACC, 8'h00, 1'b0);
    expect_last("lshft3_pass", 8'h08, 8'h08);
    req(OP_LSHFT, 8'h08, 1'b0);
    expect_last("lshft8", 8'h00, 8'h00);
    check_val("lshft8_zero", last_z0, 32'd1);

    req(OP_PASS_VAL, 8'h33, 1'b1);
    req(OP_UNK, 8'hAA, 1'b1);
    expect_last("illegal", 8'h33, 8'h33);
    check_val("illegal_flag", last_il, 32'd1);
    check_val("illegal_acc", 32'(ifc0.acc), 32'h33);

    req(OP_PASS_VAL, 8'hC5, 1'b1);
    expect_last("pre_rshft", 8'hC5, 8'hC5);
    req(OP_RSHFT, 8'h05, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    macc0 = 0; macc1 = 0; ready_edge = 0;
    check_val("abort_acc0", 32'(ifc0.acc), 32'd0);
    check_val("abort_acc1", 32'(ifc1.acc), 32'd0);
    check_val("abort_in_ready", 32'(ifc0.in_ready), 32'd1);
    check_val("abort_out_valid", 32'(ifc0.out_valid), 32'd0);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      rop = (r < 16) ? 4'(r) : ((r < 18) ? OP_LSHFT : OP_RSHFT);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      req(rop, 8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0));
    end
    expect_last("final", 8'(macc0 == macc0 ? last_r0 : 0), 8'(last_r1));
    check_val("final_acc0", 32'(ifc0.acc), macc0);
    check_val("final_acc1", 32'(ifc1.acc), macc1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
